// File: rtl/mem_access_unit_pkg.sv
// ============================================================================
//  Module   : mem_access_unit_pkg
//  Purpose  : Shared widths, one-hot op indices and FSM encoding for the
//             memory-access stage (optional feature macro: MEM_MISALIGN_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_access_unit_pkg;

    localparam int XLEN        = 32;
    localparam int STRB_W      = XLEN / 8;
    localparam int STORE_WIDTH = 3;
    localparam int LOAD_WIDTH  = 5;
    localparam int PC_WIDTH    = 32;
    localparam int INSTR_WIDTH = 32;

    // One-hot bit positions: store {SW,SH,SB}, load {LHU,LBU,LW,LH,LB}
    localparam int SB  = 0;
    localparam int SH  = 1;
    localparam int SW  = 2;
    localparam int LB  = 0;
    localparam int LH  = 1;
    localparam int LW  = 2;
    localparam int LBU = 3;
    localparam int LHU = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } mau_state_e;

endpackage : mem_access_unit_pkg

`default_nettype wire

// File: rtl/mem_lane_align.sv
// ============================================================================
//  Module   : mem_lane_align
//  Purpose  : Store lane replication/strobes and load lane select/extension.
//             Misalignment detection only exists when MEM_MISALIGN_EN is set.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_lane_align
    import mem_access_unit_pkg::*;
(
    input  logic [STORE_WIDTH-1:0] store_op_i,
    input  logic [LOAD_WIDTH-1:0]  load_op_i,
    input  logic [1:0]             addr_lo_i,
    input  logic [XLEN-1:0]        rs2_data_i,
    input  logic [XLEN-1:0]        rdata_i,
    output logic [XLEN-1:0]        wdata_o,
    output logic [STRB_W-1:0]      wstrb_o,
    output logic [XLEN-1:0]        load_data_o,
    output logic                   misalign_o
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        wdata_o = rs2_data_i;
        wstrb_o = '0;
        if (store_op_i[SB]) begin
            wdata_o = {4{rs2_data_i[7:0]}};
            wstrb_o = 4'b0001 << addr_lo_i;
        end else if (store_op_i[SH]) begin
            // Halfword lane comes from addr[1] only; addr[0] is ignored
            wdata_o = {2{rs2_data_i[15:0]}};
            wstrb_o = 4'b0011 << {addr_lo_i[1], 1'b0};
        end else if (store_op_i[SW]) begin
            wstrb_o = 4'b1111;
        end
    end

    always_comb begin
        case (addr_lo_i)
            2'd0:    w_byte = rdata_i[7:0];
            2'd1:    w_byte = rdata_i[15:8];
            2'd2:    w_byte = rdata_i[23:16];
            default: w_byte = rdata_i[31:24];
        endcase
        w_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

        load_data_o = rdata_i;
        if (load_op_i[LB]) begin
            load_data_o = {{24{w_byte[7]}}, w_byte};
        end else if (load_op_i[LBU]) begin
            load_data_o = {24'd0, w_byte};
        end else if (load_op_i[LH]) begin
            load_data_o = {{16{w_half[15]}}, w_half};
        end else if (load_op_i[LHU]) begin
            load_data_o = {16'd0, w_half};
        end
    end

`ifdef MEM_MISALIGN_EN
    assign misalign_o = ((load_op_i[LH] | load_op_i[LHU] | store_op_i[SH]) & addr_lo_i[0])
                      | ((load_op_i[LW] | store_op_i[SW]) & (|addr_lo_i));
`else
    assign misalign_o = 1'b0;
`endif

endmodule : mem_lane_align

`default_nettype wire

// File: rtl/mem_access_unit.sv
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Memory stage: runs ED loads/stores over a req/gnt/rvalid port,
//             stalls the front end meanwhile (feature macro: MEM_MISALIGN_EN).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_unit
    import mem_access_unit_pkg::*;
(
    input  logic                   clk_i,
    input  logic                   rst_n,
    input  logic [STORE_WIDTH-1:0] ED_store_op_i,
    input  logic [LOAD_WIDTH-1:0]  ED_load_op_i,
    input  logic [XLEN-1:0]        ED_valE_i,
    input  logic [XLEN-1:0]        ED_rs2_data_i,
    input  logic                   ED_commit_i,
    input  logic                   ED_need_dstE_i,
    input  logic [4:0]             ED_dstE_i,
    input  logic [PC_WIDTH-1:0]    ED_PC_i,
    input  logic [INSTR_WIDTH-1:0] ED_instr_i,
    output logic                   M_stall_o,
    output logic [XLEN-1:0]        M_result_o,
    output logic                   M_valid_o,
    output logic                   M_need_dstE_o,
    output logic [4:0]             M_dstE_o,
    output logic [PC_WIDTH-1:0]    M_PC_o,
    output logic [INSTR_WIDTH-1:0] M_instr_o,
    output logic                   M_misalign_o,
    output logic                   dmem_req_o,
    output logic                   dmem_we_o,
    output logic [XLEN-1:0]        dmem_addr_o,
    output logic [XLEN-1:0]        dmem_wdata_o,
    output logic [STRB_W-1:0]      dmem_wstrb_o,
    input  logic                   dmem_gnt_i,
    input  logic                   dmem_rvalid_i,
    input  logic [XLEN-1:0]        dmem_rdata_i
);

    mau_state_e      state_q, state_d;
    logic [XLEN-1:0] rdata_buf_q, rdata_buf_d;

    logic            w_is_store;
    logic            w_is_load;
    logic            w_mem_op;
    logic            w_lane_misalign;
    logic            w_misalign;
    logic            w_access;
    logic [XLEN-1:0] w_load_data;

    assign w_is_store = |ED_store_op_i;
    assign w_is_load  = |ED_load_op_i;
    assign w_mem_op   = ED_commit_i & (w_is_store | w_is_load);
    // A misaligned op never reaches the bus; it completes at once with a flag
    assign w_misalign = w_mem_op & w_lane_misalign;
    assign w_access   = w_mem_op & ~w_misalign;

    mem_lane_align u_lane_align (
        .store_op_i  (ED_store_op_i),
        .load_op_i   (ED_load_op_i),
        .addr_lo_i   (ED_valE_i[1:0]),
        .rs2_data_i  (ED_rs2_data_i),
        .rdata_i     (rdata_buf_q),
        .wdata_o     (dmem_wdata_o),
        .wstrb_o     (dmem_wstrb_o),
        .load_data_o (w_load_data),
        .misalign_o  (w_lane_misalign)
    );

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rdata_buf_q <= '0;
        end else begin
            state_q     <= state_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rdata_buf_d = rdata_buf_q;
        case (state_q)
            IDLE: begin
                if (w_access) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (dmem_gnt_i) begin
                    state_d = w_is_store ? DONE : WAIT_R;
                end
            end
            WAIT_R: begin
                if (dmem_rvalid_i) begin
                    rdata_buf_d = dmem_rdata_i;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign dmem_req_o  = (state_q == REQ);
    assign dmem_we_o   = w_is_store;
    assign dmem_addr_o = {ED_valE_i[XLEN-1:2], 2'b00};

    assign M_stall_o    = w_access & (state_q != DONE);
    assign M_valid_o    = ED_commit_i & (~w_access | (state_q == DONE));
    assign M_misalign_o = w_misalign;
    assign M_result_o   = w_misalign ? '0 : (w_is_load ? w_load_data : ED_valE_i);

    assign M_need_dstE_o = ED_need_dstE_i;
    assign M_dstE_o      = ED_dstE_i;
    assign M_PC_o        = ED_PC_i;
    assign M_instr_o     = ED_instr_i;

endmodule : mem_access_unit

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench with a result scoreboard for
//             mem_access_unit (honours MEM_MISALIGN_EN if defined).
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mem_access_unit;
    import mem_access_unit_pkg::*;

    logic                   clk_i = 1'b0;
    logic                   rst_n;
    logic [STORE_WIDTH-1:0] ED_store_op_i;
    logic [LOAD_WIDTH-1:0]  ED_load_op_i;
    logic [XLEN-1:0]        ED_valE_i;
    logic [XLEN-1:0]        ED_rs2_data_i;
    logic                   ED_commit_i;
    logic                   ED_need_dstE_i;
    logic [4:0]             ED_dstE_i;
    logic [PC_WIDTH-1:0]    ED_PC_i;
    logic [INSTR_WIDTH-1:0] ED_instr_i;
    logic                   M_stall_o;
    logic [XLEN-1:0]        M_result_o;
    logic                   M_valid_o;
    logic                   M_need_dstE_o;
    logic [4:0]             M_dstE_o;
    logic [PC_WIDTH-1:0]    M_PC_o;
    logic [INSTR_WIDTH-1:0] M_instr_o;
    logic                   M_misalign_o;
    logic                   dmem_req_o;
    logic                   dmem_we_o;
    logic [XLEN-1:0]        dmem_addr_o;
    logic [XLEN-1:0]        dmem_wdata_o;
    logic [STRB_W-1:0]      dmem_wstrb_o;
    logic                   dmem_gnt_i;
    logic                   dmem_rvalid_i;
    logic [XLEN-1:0]        dmem_rdata_i;

    typedef struct {
        string       tag;
        logic [31:0] res;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk_i = ~clk_i;

    mem_access_unit dut (
        .clk_i          (clk_i),
        .rst_n          (rst_n),
        .ED_store_op_i  (ED_store_op_i),
        .ED_load_op_i   (ED_load_op_i),
        .ED_valE_i      (ED_valE_i),
        .ED_rs2_data_i  (ED_rs2_data_i),
        .ED_commit_i    (ED_commit_i),
        .ED_need_dstE_i (ED_need_dstE_i),
        .ED_dstE_i      (ED_dstE_i),
        .ED_PC_i        (ED_PC_i),
        .ED_instr_i     (ED_instr_i),
        .M_stall_o      (M_stall_o),
        .M_result_o     (M_result_o),
        .M_valid_o      (M_valid_o),
        .M_need_dstE_o  (M_need_dstE_o),
        .M_dstE_o       (M_dstE_o),
        .M_PC_o         (M_PC_o),
        .M_instr_o      (M_instr_o),
        .M_misalign_o   (M_misalign_o),
        .dmem_req_o     (dmem_req_o),
        .dmem_we_o      (dmem_we_o),
        .dmem_addr_o    (dmem_addr_o),
        .dmem_wdata_o   (dmem_wdata_o),
        .dmem_wstrb_o   (dmem_wstrb_o),
        .dmem_gnt_i     (dmem_gnt_i),
        .dmem_rvalid_i  (dmem_rvalid_i),
        .dmem_rdata_i   (dmem_rdata_i)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    endtask

    task automatic push(input string tag, input logic [31:0] r);
        exp_t e;
        e.tag = tag;
        e.res = r;
        sb_q.push_back(e);
    endtask

    task automatic pop_check(input string tag);
        exp_t e;
        chk({tag, "_valid"}, M_valid_o, 1);
        chk({tag, "_sb_nonempty"}, 32'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({e.tag, "_result"}, M_result_o, e.res);
        end
    endtask

    task automatic drive(input logic [2:0] st, input logic [4:0] ld, input logic [31:0] vale,
                         input logic [31:0] rs2, input logic commit);
        ED_store_op_i  = st;
        ED_load_op_i   = ld;
        ED_valE_i      = vale;
        ED_rs2_data_i  = rs2;
        ED_commit_i    = commit;
        ED_need_dstE_i = commit;
        ED_dstE_i      = vale[4:0];
        ED_PC_i        = vale + 32'h100;
        ED_instr_i     = ~vale;
    endtask

    task automatic drive_idle();
        drive(3'b000, 5'b00000, 32'h0, 32'h0, 1'b0);
        dmem_gnt_i    = 1'b0;
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
    endtask

    // Called at a negedge with the op already driven and the DUT in IDLE.
    task automatic mem_txn(input string tag, input int gnt_dly, input logic [31:0] rdata,
                           input logic [31:0] exp_addr, input logic [31:0] exp_wdata,
                           input logic [3:0] exp_strb, input logic exp_we);
        #1;
        chk({tag, "_idle_stall"}, M_stall_o, 1);
        chk({tag, "_idle_req"}, dmem_req_o, 0);
        chk({tag, "_idle_valid"}, M_valid_o, 0);
        @(negedge clk_i);
        for (int i = 0; i < gnt_dly; i++) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = 32'hBADB_AD00;
            #1;
            chk({tag, "_wait_req"}, dmem_req_o, 1);
            chk({tag, "_wait_addr"}, dmem_addr_o, exp_addr);
            chk({tag, "_wait_strb"}, 32'(dmem_wstrb_o), 32'(exp_strb));
            if (exp_we) chk({tag, "_wait_wdata"}, dmem_wdata_o, exp_wdata);
            chk({tag, "_wait_stall"}, M_stall_o, 1);
            @(negedge clk_i);
        end
        dmem_rvalid_i = 1'b0;
        dmem_gnt_i    = 1'b1;
        #1;
        chk({tag, "_req"}, dmem_req_o, 1);
        chk({tag, "_we"}, dmem_we_o, 32'(exp_we));
        chk({tag, "_addr"}, dmem_addr_o, exp_addr);
        chk({tag, "_strb"}, 32'(dmem_wstrb_o), 32'(exp_strb));
        if (exp_we) chk({tag, "_wdata"}, dmem_wdata_o, exp_wdata);
        chk({tag, "_req_stall"}, M_stall_o, 1);
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        if (!exp_we) begin
            dmem_rvalid_i = 1'b1;
            dmem_rdata_i  = rdata;
            #1;
            chk({tag, "_waitr_stall"}, M_stall_o, 1);
            chk({tag, "_waitr_valid"}, M_valid_o, 0);
            chk({tag, "_waitr_req"}, dmem_req_o, 0);
            @(negedge clk_i);
            dmem_rvalid_i = 1'b0;
            dmem_rdata_i  = 32'h0;
        end
        #1;
        chk({tag, "_done_stall"}, M_stall_o, 0);
        chk({tag, "_done_req"}, dmem_req_o, 0);
        pop_check(tag);
        @(negedge clk_i);
        drive_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        drive_idle();

        // Reset state
        @(negedge clk_i);
        drive(3'b000, 5'b00100, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rst_req", dmem_req_o, 0);
        chk("rst_stall", M_stall_o, 0);
        chk("rst_valid", M_valid_o, 0);
        chk("rst_misalign", M_misalign_o, 0);
        chk("rst_buf", M_result_o, 32'h0);
        @(negedge clk_i);
        rst_n = 1'b1;
        drive_idle();

        // SW, zero-wait grant
        @(negedge clk_i);
        drive(3'b100, 5'b00000, 32'h0000_1004, 32'hDEAD_BEEF, 1'b1);
        push("sw", 32'h0000_1004);
        mem_txn("sw", 0, 32'h0, 32'h0000_1004, 32'hDEAD_BEEF, 4'b1111, 1'b1);

        // LB / non-memory / LBU
        @(negedge clk_i);
        drive(3'b000, 5'b00001, 32'h0000_2003, 32'h0, 1'b1);
        push("lb", 32'hFFFF_FF80);
        mem_txn("lb", 0, 32'h80FF_1234, 32'h0000_2000, 32'h0, 4'b0000, 1'b0);

        drive(3'b000, 5'b00000, 32'h0000_0055, 32'h0, 1'b1);
        push("alu", 32'h0000_0055);
        #1;
        chk("alu_stall", M_stall_o, 0);
        chk("alu_req", dmem_req_o, 0);
        chk("alu_pc", M_PC_o, 32'h0000_0155);
        chk("alu_instr", M_instr_o, 32'hFFFF_FFAA);
        chk("alu_dst", 32'(M_dstE_o), 32'h15);
        chk("alu_need", M_need_dstE_o, 1);
        pop_check("alu");
        @(negedge clk_i);
        #1;
        chk("alu_after_req", dmem_req_o, 0);

        @(negedge clk_i);
        drive(3'b000, 5'b01000, 32'h0000_2003, 32'h0, 1'b1);
        push("lbu", 32'h0000_0080);
        mem_txn("lbu", 0, 32'h80FF_1234, 32'h0000_2000, 32'h0, 4'b0000, 1'b0);

        // LH / LHU on the upper half, grant delayed with spurious rvalid in REQ
        @(negedge clk_i);
        drive(3'b000, 5'b00010, 32'h0000_2002, 32'h0, 1'b1);
        push("lh", 32'hFFFF_80FF);
        mem_txn("lh", 2, 32'h80FF_1234, 32'h0000_2000, 32'h0, 4'b0000, 1'b0);
        @(negedge clk_i);
        drive(3'b000, 5'b10000, 32'h0000_2002, 32'h0, 1'b1);
        push("lhu", 32'h0000_80FF);
        mem_txn("lhu", 0, 32'h80FF_1234, 32'h0000_2000, 32'h0, 4'b0000, 1'b0);

        // SH lane 0 with a 3-cycle grant wait; SB lane 1
        @(negedge clk_i);
        drive(3'b010, 5'b00000, 32'h0000_0010, 32'h0000_ABCD, 1'b1);
        push("sh", 32'h0000_0010);
        mem_txn("sh", 3, 32'h0, 32'h0000_0010, 32'hABCD_ABCD, 4'b0011, 1'b1);
        @(negedge clk_i);
        drive(3'b001, 5'b00000, 32'h0000_3001, 32'h1234_5677, 1'b1);
        push("sb", 32'h0000_3001);
        mem_txn("sb", 1, 32'h0, 32'h0000_3000, 32'h7777_7777, 4'b0010, 1'b1);

        // Stale op bits with commit low
        @(negedge clk_i);
        drive(3'b100, 5'b00000, 32'h0000_0099, 32'h1, 1'b0);
        #1;
        chk("stale_stall", M_stall_o, 0);
        chk("stale_valid", M_valid_o, 0);
        @(negedge clk_i);
        #1;
        chk("stale_req", dmem_req_o, 0);
        @(negedge clk_i);
        drive_idle();

        // Reset while waiting for read data; later rvalid must be ignored
        @(negedge clk_i);
        drive(3'b000, 5'b00100, 32'h0000_0040, 32'h0, 1'b1);
        @(negedge clk_i);
        dmem_gnt_i = 1'b1;
        @(negedge clk_i);
        dmem_gnt_i = 1'b0;
        #1;
        chk("abort_waitr_stall", M_stall_o, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_req", dmem_req_o, 0);
        chk("abort_valid", M_valid_o, 0);
        @(negedge clk_i);
        rst_n = 1'b1;
        drive_idle();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'hCAFE_F00D;
        #1;
        chk("abort_rv_valid", M_valid_o, 0);
        @(negedge clk_i);
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        drive(3'b000, 5'b00100, 32'h0000_0040, 32'h0, 1'b0);
        #1;
        chk("abort_buf", M_result_o, 32'h0);
        chk("abort_req2", dmem_req_o, 0);
        chk("abort_valid2", M_valid_o, 0);
        @(negedge clk_i);
        drive_idle();

        // LW at a misaligned address
        @(negedge clk_i);
        drive(3'b000, 5'b00100, 32'h0000_1002, 32'h0, 1'b1);
`ifdef MEM_MISALIGN_EN
        push("lw_mis", 32'h0);
        #1;
        chk("lw_mis_flag", M_misalign_o, 1);
        chk("lw_mis_stall", M_stall_o, 0);
        pop_check("lw_mis");
        @(negedge clk_i);
        #1;
        chk("lw_mis_req", dmem_req_o, 0);
        @(negedge clk_i);
        drive_idle();
`else
        push("lw_unal", 32'h1122_3344);
        #1;
        chk("lw_unal_flag", M_misalign_o, 0);
        mem_txn("lw_unal", 0, 32'h1122_3344, 32'h0000_1000, 32'h0, 4'b0000, 1'b0);
`endif

        @(negedge clk_i);
        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_mem_access_unit

`default_nettype wire
